// File: rtl/fp_pkg.sv
// Shared constants, flag positions and FSM state encoding for the
// floating-point post-adder normalization stage.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 24;
    localparam int FRAC_W  = MAN_W - 1;
    localparam int RES_W   = 1 + EXP_W + FRAC_W;
    localparam int FLAG_W  = 3;
    localparam int SHIFT_W = 5;

    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0]   EXP_MAX   = 8'hFF;
    localparam logic [SHIFT_W-1:0] MAX_SHIFT = 5'd23;

    // Bit positions inside the {overflow, underflow, zero} flag vector
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fp_normalize_seq_if.sv
// Handshake bundle for the normalization stage: upstream result in,
// packed IEEE-754 word out. slave = the stage, master = its environment.
interface fp_normalize_seq_if;
    import fp_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [EXP_W-1:0]     in_exp;
    logic [MAN_W-1:0]     in_mant;
    logic                 in_carry;

    logic                 out_valid;
    logic                 out_ready;
    logic [RES_W-1:0]     out_result;
    logic [FLAG_W-1:0]    out_flags;
    logic [SHIFT_W-1:0]   out_shift;

    modport master (
        output in_valid,
        output in_sign,
        output in_exp,
        output in_mant,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_flags,
        input  out_shift
    );

    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_exp,
        input  in_mant,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_flags,
        output out_shift
    );

endinterface

// File: rtl/fp_pack_result.sv
// Combinational exception detection and IEEE-754 single packing.
// Ports: i_sign/i_exp(9b)/i_mant/i_carry in; o_result, o_flags, and
// o_done (low when the mantissa still needs another left shift).
module fp_pack_result
    import fp_pkg::*;
(
    input  logic               i_sign,
    input  logic [EXP_W:0]     i_exp,
    input  logic [MAN_W-1:0]   i_mant,
    input  logic               i_carry,
    output logic [RES_W-1:0]   o_result,
    output logic [FLAG_W-1:0]  o_flags,
    output logic               o_done
);

    logic [EXP_W:0] w_exp_inc;

    // Extra exponent bit lets the carry increment be compared against
    // the all-ones code without wrapping.
    assign w_exp_inc = i_exp + 9'd1;

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        o_done   = 1'b1;
        if (i_exp == {1'b0, EXP_MAX}) begin
            // Inf/NaN input exponent passes straight through
            o_result = {i_sign, EXP_MAX, i_mant[FRAC_W-1:0]};
        end else if (i_carry) begin
            // Right shift by one with the carry as new hidden bit;
            // the dropped LSB is truncated.
            if (w_exp_inc == {1'b0, EXP_MAX}) begin
                o_result          = {i_sign, EXP_MAX, {FRAC_W{1'b0}}};
                o_flags[FLAG_OVF] = 1'b1;
            end else begin
                o_result = {i_sign, w_exp_inc[EXP_W-1:0],
                            i_mant[MAN_W-1:1]};
            end
        end else if (i_mant == '0) begin
            // Exact cancellation always yields +0
            o_result           = '0;
            o_flags[FLAG_ZERO] = 1'b1;
        end else if (i_mant[MAN_W-1]) begin
            o_result = {i_sign, i_exp[EXP_W-1:0],
                        i_mant[FRAC_W-1:0]};
        end else if (i_exp <= 9'd1) begin
            // No denormal support: flush to signed zero
            o_result          = {i_sign, {(RES_W-1){1'b0}}};
            o_flags[FLAG_UNF] = 1'b1;
        end else begin
            o_done = 1'b0;
        end
    end

endmodule

// File: rtl/fp_normalize_seq.sv
// Iterative normalizer: one left shift per cycle until the hidden bit
// is set, then packs the word. Ports: clk, rst (sync, active-high),
// bus (slave modport: in_* upstream handshake, out_* downstream).
module fp_normalize_seq
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fp_normalize_seq_if.slave   bus
);

    state_t               r_state;
    logic                 r_sign;
    logic [EXP_W:0]       r_exp;
    logic [MAN_W-1:0]     r_mant;
    logic                 r_carry;
    logic [SHIFT_W-1:0]   r_shift;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [RES_W-1:0]     r_result;
    logic [FLAG_W-1:0]    r_flags;
    logic [SHIFT_W-1:0]   r_out_shift;

    logic [RES_W-1:0]     w_result;
    logic [FLAG_W-1:0]    w_flags;
    logic                 w_done;

    fp_pack_result u_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_mant   (r_mant),
        .i_carry  (r_carry),
        .o_result (w_result),
        .o_flags  (w_flags),
        .o_done   (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_carry     <= 1'b0;
            r_shift     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_shift <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_sign;
                        r_exp      <= {1'b0, bus.in_exp};
                        r_mant     <= bus.in_mant;
                        r_carry    <= bus.in_carry;
                        r_shift    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= NORM;
                    end
                end
                NORM: begin
                    if (w_done) begin
                        r_result    <= w_result;
                        r_flags     <= w_flags;
                        r_out_shift <= r_shift;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 9'd1;
                        // A nonzero mantissa reaches the hidden bit
                        // before the count can pass MAX_SHIFT.
                        if (r_shift != MAX_SHIFT) begin
                            r_shift <= r_shift + 5'd1;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_result;
    assign bus.out_flags  = r_flags;
    assign bus.out_shift  = r_out_shift;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// Self-checking bench for fp_normalize_seq: directed vector table,
// hand sequences for backpressure and reset, and random vs. a model.
module tb_fp_normalize_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fp_normalize_seq_if bus ();

    fp_normalize_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        c;
        int          hold;
        logic [31:0] res;
        logic [2:0]  fl;
        int          sh;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    // Reference model from the normalization rules: count leading
    // zeros, then decide whether the exponent budget runs out first.
    function automatic void model(input logic s, input logic [7:0] e,
                                  input logic [23:0] m, input logic c,
                                  output logic [31:0] r,
                                  output logic [2:0] f, output int sh);
        int ei;
        int mv;
        int lz;
        ei = int'(e);
        sh = 0;
        f  = 3'b000;
        r  = 32'd0;
        if (e == 8'hFF) begin
            r = {s, 8'hFF, m[22:0]};
        end else if (c) begin
            ei = ei + 1;
            if (ei == 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 3'b100;
            end else begin
                r = {s, 8'(ei), m[23:1]};
            end
        end else if (m == 24'd0) begin
            r = 32'd0;
            f = 3'b001;
        end else begin
            mv = int'(m);
            lz = 0;
            while (mv < 32'h800000) begin
                mv = mv * 2;
                lz++;
            end
            if (lz == 0 || ei - lz >= 1) begin
                sh = lz;
                r  = {s, 8'(ei - lz), 23'(mv)};
            end else begin
                sh = (ei <= 1) ? 0 : ei - 1;
                r  = {s, 31'd0};
                f  = 3'b010;
            end
        end
    endfunction

    task automatic do_op(input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic c,
                         input int hold, input logic [31:0] xr,
                         input logic [2:0] xf, input int xs,
                         input string tag);
        int lat;
        logic [31:0] r0;
        logic [2:0] f0;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.in_carry = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_mant  = 24'($urandom());
        bus.in_exp   = 8'($urandom());
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(1 + xs));
        chk({tag, "_result"}, bus.out_result, xr);
        chk({tag, "_flags"}, 32'(bus.out_flags), 32'(xf));
        chk({tag, "_shift"}, 32'(bus.out_shift), 32'(xs));
        r0 = bus.out_result;
        f0 = bus.out_flags;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sign  = 1'($urandom());
            bus.in_mant  = 24'($urandom());
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_result"}, bus.out_result, r0);
            chk({tag, "_hold_flags"}, 32'(bus.out_flags), 32'(f0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xr;
        logic [2:0]  xf;
        int          xs;
        logic        rs;
        logic [7:0]  re;
        logic [23:0] rm;
        logic        rc;

        tbl[0] = '{1'b0, 8'd127, 24'h800000, 1'b0, 5, 32'h3F800000, 3'b000, 0};
        tbl[1] = '{1'b0, 8'd127, 24'h000000, 1'b1, 0, 32'h40000000, 3'b000, 0};
        tbl[2] = '{1'b0, 8'd130, 24'h000001, 1'b0, 0, 32'h35800000, 3'b000, 23};
        tbl[3] = '{1'b0, 8'd254, 24'h000000, 1'b1, 0, 32'h7F800000, 3'b100, 0};
        tbl[4] = '{1'b1, 8'd100, 24'h000000, 1'b0, 0, 32'h00000000, 3'b001, 0};
        tbl[5] = '{1'b1, 8'd3,   24'h000010, 1'b0, 0, 32'h80000000, 3'b010, 2};
        tbl[6] = '{1'b1, 8'hFF,  24'h123456, 1'b0, 0, 32'hFF923456, 3'b000, 0};
        tbl[7] = '{1'b0, 8'd10,  24'hC00001, 1'b1, 0, 32'h05E00000, 3'b000, 0};
        tbl[8] = '{1'b0, 8'd1,   24'h800001, 1'b0, 0, 32'h00800001, 3'b000, 0};
        tbl[9] = '{1'b0, 8'd1,   24'h400000, 1'b0, 0, 32'h00000000, 3'b010, 0};

        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd0;
        bus.in_mant   = 24'd0;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_flags", 32'(bus.out_flags), 32'd0);
        chk("rst_shift", 32'(bus.out_shift), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].c, tbl[i].hold,
                  tbl[i].res, tbl[i].fl, tbl[i].sh,
                  $sformatf("vec%0d", i));
        end

        // Reset while ten shifts into a 23-shift normalization
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'd130;
        bus.in_mant  = 24'h000001;
        bus.in_carry = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_norm_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_result", bus.out_result, 32'd0);
        do_op(1'b0, 8'd127, 24'h800000, 1'b0, 0,
              32'h3F800000, 3'b000, 0, "after_rst");

        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom());
            case ($urandom_range(0, 3))
                0: re = 8'($urandom_range(0, 25));
                1: re = 8'($urandom_range(245, 255));
                default: re = 8'($urandom());
            endcase
            rm = 24'($urandom()) >> $urandom_range(0, 24);
            rc = ($urandom_range(0, 3) == 0);
            model(rs, re, rm, rc, xr, xf, xs);
            do_op(rs, re, rm, rc, $urandom_range(0, 2), xr, xf, xs,
                  $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
